// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART transmit path.
//   ARB_IDLE / ARB_ISSUE / ARB_WAIT : arbiter FSM state encoding
//   UART_DATA_W                      : serializer byte width
// -----------------------------------------------------------------------------
package uart_pkg;
  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_WAIT  = 2'd2;

  localparam int UART_DATA_W = 8;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Scans the request vector upward starting
// one past the pointer, wrapping at NUM_REQ-1 back to 0.
// Ports:
//   i_req   [NUM_REQ-1:0] : request vector
//   i_ptr   [IDX_W-1:0]   : index of the most recent winner
//   o_idx   [IDX_W-1:0]   : winning index (valid when o_found)
//   o_found               : at least one request is set
// -----------------------------------------------------------------------------
module rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_found
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [IDX_W:0]       w_start;
  logic [NUM_REQ-1:0]   w_rot;

  // Duplicating the vector lets a plain right shift act as a rotate, so bit 0
  // of w_rot is the request at index ptr+1 (mod NUM_REQ).
  assign w_start = {1'b0, i_ptr} + 1'b1;
  assign w_dbl   = {i_req, i_req};
  assign w_rot   = NUM_REQ'(w_dbl >> w_start);

  // Descending loop so the lowest set rotated bit is the one that sticks.
  always_comb begin
    logic [IDX_W+1:0] v_sum;
    o_found = 1'b0;
    o_idx   = '0;
    v_sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_found = 1'b1;
        v_sum   = (IDX_W+2)'(w_start) + (IDX_W+2)'(k);
        if (v_sum >= (IDX_W+2)'(NUM_REQ)) begin
          v_sum = v_sum - (IDX_W+2)'(NUM_REQ);
        end
        o_idx = v_sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin sharing of one uart_tx serializer between NUM_REQ byte
// producers. One byte is accepted per grant; the next arbitration waits for
// the serializer's Tx_Done.
// Ports:
//   Clk, Rst                : clock, synchronous active-high reset
//   Req_Valid [NUM_REQ-1:0] : requester i has a byte pending
//   Req_Data  [8*NUM_REQ-1:0]: byte of requester i at [8*i+7:8*i]
//   Req_Lock  [NUM_REQ-1:0] : keep-grant hint
//   Req_Ready [NUM_REQ-1:0] : one-hot accept pulse (combinational)
//   Tx_Start                : one-cycle start pulse to the serializer
//   Tx_Byte   [7:0]         : byte to the serializer
//   Tx_Active, Tx_Done      : serializer busy flag / completion pulse
//   Grant_Id  [IDX_W-1:0]   : current or most recent winner
//   Busy                    : FSM is not in IDLE
// Build option:
//   UART_TX_ARB_LOCK_EN : when defined, a requester holding Req_Lock at
//                         Tx_Done keeps priority for its next byte.
// -----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic [NUM_REQ-1:0]             Req_Valid,
  input  logic [UART_DATA_W*NUM_REQ-1:0] Req_Data,
  input  logic [NUM_REQ-1:0]             Req_Lock,
  output logic [NUM_REQ-1:0]             Req_Ready,
  output logic                           Tx_Start,
  output logic [UART_DATA_W-1:0]         Tx_Byte,
  input  logic                           Tx_Active,
  input  logic                           Tx_Done,
  output logic [IDX_W-1:0]               Grant_Id,
  output logic                           Busy
);

  logic [1:0]             r_state;
  logic [1:0]             w_next;
  logic [IDX_W-1:0]       r_ptr;
  logic [IDX_W-1:0]       r_grant;
  logic [UART_DATA_W-1:0] r_byte;
  logic                   r_busy;
  logic [IDX_W-1:0]       w_win;
  logic                   w_found;
  logic                   w_accept;
  logic                   w_ptr_adv;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req   (Req_Valid),
    .i_ptr   (r_ptr),
    .o_idx   (w_win),
    .o_found (w_found)
  );

  // Tx_Active gate also covers a serializer still shifting after our reset.
  assign w_accept = (r_state == ARB_IDLE) && !Tx_Active && w_found;

`ifdef UART_TX_ARB_LOCK_EN
  assign w_ptr_adv = !Req_Lock[r_grant];
`else
  logic w_unused_lock;
  assign w_unused_lock = ^Req_Lock;
  assign w_ptr_adv     = 1'b1;
`endif

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= ARB_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ARB_IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE:  if (w_accept) w_next = ARB_ISSUE;
      ARB_ISSUE: w_next = ARB_WAIT;
      ARB_WAIT:  if (Tx_Done) w_next = ARB_IDLE;
      default:   w_next = ARB_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    Req_Ready = '0;
    Tx_Start  = 1'b0;
    if (w_accept) Req_Ready[w_win] = 1'b1;
    if (r_state == ARB_ISSUE) Tx_Start = 1'b1;
  end

  // Byte capture, grant and pointer bookkeeping
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_ptr   <= IDX_W'(NUM_REQ - 1);
      r_grant <= '0;
      r_byte  <= '0;
    end else begin
      if (w_accept) begin
        r_byte  <= Req_Data[UART_DATA_W*w_win +: UART_DATA_W];
        r_grant <= w_win;
      end
      if ((r_state == ARB_WAIT) && Tx_Done && w_ptr_adv) begin
        r_ptr <= r_grant;
      end
    end
  end

  assign Tx_Byte  = r_byte;
  assign Grant_Id = r_grant;
  assign Busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic [N-1:0] Req_Valid = '0;
  logic [8*N-1:0] Req_Data = '0;
  logic [N-1:0] Req_Lock = '0;
  logic [N-1:0] Req_Ready;
  logic         Tx_Start;
  logic [7:0]   Tx_Byte;
  logic         Tx_Active = 1'b0;
  logic         Tx_Done = 1'b0;
  logic [1:0]   Grant_Id;
  logic         Busy;

  int errors = 0;
  int checks = 0;
  int m_ptr  = N - 1;

  uart_tx_arbiter #(.NUM_REQ(N)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Req_Valid (Req_Valid),
    .Req_Data  (Req_Data),
    .Req_Lock  (Req_Lock),
    .Req_Ready (Req_Ready),
    .Tx_Start  (Tx_Start),
    .Tx_Byte   (Tx_Byte),
    .Tx_Active (Tx_Active),
    .Tx_Done   (Tx_Done),
    .Grant_Id  (Grant_Id),
    .Busy      (Busy)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: first valid index going upward from ptr+1, modulo N.
  function automatic int model_pick(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic do_reset();
    tick();
    Rst = 1'b1;
    Req_Valid = '0;
    tick();
    Rst = 1'b0;
    m_ptr = N - 1;
  endtask

  // One complete byte: accept in IDLE, ISSUE, frame cycles busy, Tx_Done.
  task automatic xfer(input logic [N-1:0] valid, input logic [N-1:0] wait_valid,
                      input logic [31:0] data, input logic [N-1:0] lock,
                      input int frame, input bit stray, output int win);
    logic [7:0] b;
    Req_Valid = valid;
    Req_Data  = data;
    Req_Lock  = lock;
    Tx_Active = 1'b0;
    Tx_Done   = stray;
    #1;
    win = model_pick(valid);
    b   = data[8*win +: 8];
    chk("accept_ready", 32'(Req_Ready), 32'(1) << win);
    chk("idle_busy", 32'(Busy), 0);
    chk("idle_start", 32'(Tx_Start), 0);
    tick();
    Req_Valid = wait_valid;
    Req_Data  = $urandom;
    Tx_Done   = 1'b0;
    #1;
    chk("issue_start", 32'(Tx_Start), 1);
    chk("issue_byte", 32'(Tx_Byte), 32'(b));
    chk("issue_grant", 32'(Grant_Id), win);
    chk("issue_busy", 32'(Busy), 1);
    chk("issue_ready", 32'(Req_Ready), 0);
    for (int c = 0; c < frame; c++) begin
      tick();
      Tx_Active = 1'b1;
      #1;
      chk("wait_start", 32'(Tx_Start), 0);
      chk("wait_ready", 32'(Req_Ready), 0);
      chk("wait_byte", 32'(Tx_Byte), 32'(b));
      chk("wait_busy", 32'(Busy), 1);
    end
    tick();
    Tx_Active = 1'b0;
    Tx_Done   = 1'b1;
    #1;
    chk("done_ready", 32'(Req_Ready), 0);
    chk("done_busy", 32'(Busy), 1);
    chk("done_start", 32'(Tx_Start), 0);
`ifdef UART_TX_ARB_LOCK_EN
    if (!lock[win]) m_ptr = win;
`else
    m_ptr = win;
`endif
    tick();
    Tx_Done = 1'b0;
  endtask

  initial begin
    int w;
    int lk_exp[6];

    // Reset values
    tick();
    tick();
    chk("rst_ready", 32'(Req_Ready), 0);
    chk("rst_start", 32'(Tx_Start), 0);
    chk("rst_byte", 32'(Tx_Byte), 0);
    chk("rst_grant", 32'(Grant_Id), 0);
    chk("rst_busy", 32'(Busy), 0);
    Rst = 1'b0;

    // Single requester, fixed byte
    xfer(4'b0001, 4'b0000, 32'h0000_00A5, 4'b0000, 3, 1'b0, w);
    chk("a5_winner", w, 0);
    #1;
    chk("a5_busy_after", 32'(Busy), 0);

    // All valid: strict rotation
    do_reset();
    for (int i = 0; i < 8; i++) begin
      xfer(4'b1111, 4'b1111, $urandom, 4'b0000, $urandom_range(1, 4), 1'b0, w);
      chk("rr_order", w, i % N);
    end

    // 1010 from Ptr=3: wrap-around
    do_reset();
    xfer(4'b1010, 4'b1010, $urandom, 4'b0000, 2, 1'b0, w);
    chk("wrap_1", w, 1);
    xfer(4'b1010, 4'b1010, $urandom, 4'b0000, 2, 1'b0, w);
    chk("wrap_2", w, 3);
    xfer(4'b1010, 4'b1010, $urandom, 4'b0000, 2, 1'b0, w);
    chk("wrap_3", w, 1);

    // Reset while the serializer is still active
    do_reset();
    xfer(4'b0010, 4'b0000, $urandom, 4'b0000, 1, 1'b0, w);
    Req_Valid = 4'b0100;
    Req_Data  = $urandom;
    #1;
    chk("mid_accept", 32'(Req_Ready), 32'(4'b0100));
    tick();
    Req_Valid = 4'b0000;
    #1;
    chk("mid_issue", 32'(Tx_Start), 1);
    tick();
    Tx_Active = 1'b1;
    tick();
    Rst = 1'b1;
    Req_Valid = 4'b1111;
    #1;
    chk("mid_rst_ready", 32'(Req_Ready), 0);
    tick();
    Rst = 1'b0;
    m_ptr = N - 1;
    #1;
    chk("mid_post_busy", 32'(Busy), 0);
    chk("mid_post_byte", 32'(Tx_Byte), 0);
    chk("mid_post_grant", 32'(Grant_Id), 0);
    for (int i = 0; i < 3; i++) begin
      chk("mid_hold_ready", 32'(Req_Ready), 0);
      chk("mid_hold_start", 32'(Tx_Start), 0);
      tick();
      #1;
    end
    xfer(4'b1111, 4'b1111, $urandom, 4'b0000, 2, 1'b1, w);
    chk("mid_first_grant", w, 0);

    // Lock hint
`ifdef UART_TX_ARB_LOCK_EN
    lk_exp = '{0, 1, 2, 2, 2, 3};
`else
    lk_exp = '{0, 1, 2, 3, 0, 1};
`endif
    do_reset();
    xfer(4'b1111, 4'b1111, $urandom, 4'b0000, 2, 1'b0, w);
    chk("lock_0", w, lk_exp[0]);
    xfer(4'b1111, 4'b1111, $urandom, 4'b0100, 2, 1'b0, w);
    chk("lock_1", w, lk_exp[1]);
    xfer(4'b1111, 4'b1111, $urandom, 4'b0100, 2, 1'b0, w);
    chk("lock_2", w, lk_exp[2]);
    xfer(4'b1111, 4'b1111, $urandom, 4'b0100, 2, 1'b0, w);
    chk("lock_3", w, lk_exp[3]);
    xfer(4'b1111, 4'b1111, $urandom, 4'b0000, 2, 1'b0, w);
    chk("lock_4", w, lk_exp[4]);
    xfer(4'b1111, 4'b1111, $urandom, 4'b0000, 2, 1'b0, w);
    chk("lock_5", w, lk_exp[5]);

    // Requester 1 withdraws while requester 0 is being served
    do_reset();
    xfer(4'b0011, 4'b0001, $urandom, 4'b0000, 3, 1'b0, w);
    chk("drop_winner", w, 0);
    Req_Valid = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("drop_ready", 32'(Req_Ready), 0);
      chk("drop_start", 32'(Tx_Start), 0);
      tick();
    end

    // Randomized traffic against the reference
    do_reset();
    for (int i = 0; i < 24; i++) begin
      logic [N-1:0] v;
      v = N'($urandom_range(1, 15));
      xfer(v, N'($urandom), $urandom, N'($urandom), $urandom_range(1, 5),
           1'($urandom), w);
      if ($urandom_range(0, 1) == 1) begin
        Req_Valid = '0;
        #1;
        chk("gap_ready", 32'(Req_Ready), 0);
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
